track_sector_sched: RTL

TRACK_SECTOR_SCHED -- requirements
Module: track_sector_sched

---
 rtl/track_sector_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/track_sector_sched.sv
// Round-robin scheduler feeding NSECT phi-sector track sources into one decipher pipeline.
// Optional per-event track cap enabled by defining SCHED_TRACK_LIMIT_EN.
module track_sector_sched #(
  parameter int NSECT   = 27,
  parameter int DEC_LAT = 4,
  parameter int MAX_TRK = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  evt_start,
  input  logic [NSECT-1:0]      sect_valid,
  input  logic [NSECT-1:0]      sect_last,
  input  logic [96*NSECT-1:0]   sect_track,
  output logic [NSECT-1:0]      sect_ready,
  output logic                  dec_valid,
  output logic [95:0]           dec_track,
  output logic [4:0]            dec_phi_sector,
  output logic                  evt_busy,
  output logic                  evt_done,
  output logic [9:0]            evt_ntrk,
  output logic                  evt_ovf,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PW = (NSECT > 1) ? $clog2(NSECT) : 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q;
  logic [NSECT-1:0] done_mask_q;
  logic [3:0]       drain_q, drain_d;
  logic [NSECT-1:0] req;
  logic [PW-1:0]    cand;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             xfer;
  logic             xfer_last;
  logic             fwd;
  logic             at_limit;
  logic             mask_full;
  logic [95:0]      gnt_track;

  // Handshake: sector i transfers in a cycle where sect_valid[i] & sect_ready[i];
  // sect_ready is at most one-hot and never depends on anything but state, pointer and requests.
  always_comb begin
    req = '0;
    if (state_q == S_RUN) req = sect_valid & ~done_mask_q;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NSECT; k++) begin
      cand = PW'((int'(ptr_q) + k) % NSECT);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    sect_ready = '0;
    if (gnt_any) sect_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_track = '0;
    for (int i = 0; i < NSECT; i++) begin
      if (gnt_idx == PW'(i)) gnt_track = sect_track[96*i +: 96];
    end
  end

  assign xfer      = gnt_any;
  assign xfer_last = sect_last[gnt_idx];
  assign mask_full = &done_mask_q;

`ifdef SCHED_TRACK_LIMIT_EN
  assign at_limit = (evt_ntrk == 10'(MAX_TRK));
`else
  logic unused_max_trk;
  assign at_limit       = 1'b0;
  assign unused_max_trk = (MAX_TRK != 0);
`endif

  // Tracks beyond the cap still complete the handshake but are not forwarded.
  assign fwd = xfer & ~at_limit;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (evt_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (mask_full) begin
          state_d = S_DRAIN;
          drain_d = 4'(DEC_LAT);
        end
      end
      S_DRAIN: begin
        if (drain_q != 4'd0) drain_d = drain_q - 4'd1;
        if (drain_q <= 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= PW'(NSECT - 1);
      done_mask_q    <= '0;
      drain_q        <= '0;
      dec_valid      <= 1'b0;
      dec_track      <= '0;
      dec_phi_sector <= '0;
      evt_ntrk       <= '0;
      evt_ovf        <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      dec_valid <= fwd;
      if (state_q == S_IDLE && evt_start) begin
        done_mask_q <= '0;
        evt_ntrk    <= '0;
        evt_ovf     <= 1'b0;
      end
      if (xfer) begin
        ptr_q <= gnt_idx;
        if (xfer_last) done_mask_q[gnt_idx] <= 1'b1;
        if (at_limit) evt_ovf <= 1'b1;
      end
      if (fwd) begin
        dec_track      <= gnt_track;
        dec_phi_sector <= 5'(gnt_idx);
        if (evt_ntrk != 10'd1023) evt_ntrk <= evt_ntrk + 10'd1;
      end
    end
  end

  assign evt_busy  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign evt_done  = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
